// File: rtl/io_map_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : io_map_pkg
//  Description : IO bus word-address map, UART status bit positions and the
//                TX state encoding shared by the IO responders.
//  Revision    : 1.0  initial release
// ============================================================================
package io_map_pkg;

  // One-hot word-address bits (word address = byte address [15:2])
  localparam int IO_LEDS_BIT      = 0;
  localparam int IO_UART_DAT_BIT  = 1;
  localparam int IO_UART_CNTL_BIT = 2;

  // UART_CNTL status word bit positions
  localparam int OVF_BIT  = 10;
  localparam int FULL_BIT = 9;
  localparam int IDLE_BIT = 8;

  // FIFO occupancy field width (enough for a 16-entry FIFO)
  localparam int COUNT_W = 5;

  // TX FSM state encoding
  localparam int         TX_STATE_W = 2;
  localparam logic [1:0] TX_IDLE    = 2'd0;
  localparam logic [1:0] TX_START   = 2'd1;
  localparam logic [1:0] TX_DATA    = 2'd2;
  localparam logic [1:0] TX_STOP    = 2'd3;

endpackage : io_map_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with saturating occupancy count. A push
//                into a full FIFO is dropped unless a pop frees a slot in the
//                same cycle; dropped pushes are flagged for one cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo
  import io_map_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               push,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic               pop,
  output logic [WIDTH-1:0]   rd_data,
  output logic               full,
  output logic               empty,
  output logic               push_drop,
  output logic [COUNT_W-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  // Reject unsupported depths at elaboration
  generate
    if ((DEPTH < 2) || (DEPTH > 16) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("sync_fifo: DEPTH must be a power of 2 between 2 and 16");
    end
  endgenerate

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               push_ok, pop_ok;

  assign full      = (count_q == COUNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign rd_data   = mem_q[rd_ptr_q];
  // A pop in the same cycle frees the slot a full-FIFO push needs
  assign pop_ok    = pop & ~empty;
  assign push_ok   = push & (~full | pop_ok);
  assign push_drop = push & ~push_ok;

  // Next-state pointers and saturating-by-construction occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while the FIFO is empty
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/io_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : io_uart_tx
//  Description : Memory-mapped UART transmitter (8N1, LSB first) with a TX
//                FIFO, a sticky overflow flag and a combinational status read.
//  Revision    : 1.0  initial release
// ============================================================================
module io_uart_tx
  import io_map_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 27000000,
  parameter int BAUD        = 115200,
  parameter int DIVISOR     = CLK_FREQ_HZ / BAUD,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] IO_mem_addr,
  input  logic [31:0] IO_mem_wdata,
  input  logic        IO_mem_wr,
  output logic [31:0] IO_mem_rdata,
  output logic        uart_tx
);

  localparam int              CW            = $clog2(DIVISOR);
  localparam logic [CW-1:0]   BIT_LAST      = CW'(DIVISOR - 1);
  localparam int              DAT_ADDR_BIT  = IO_UART_DAT_BIT + 2;
  localparam int              CNTL_ADDR_BIT = IO_UART_CNTL_BIT + 2;

  // Reject a divisor too small to form a bit period
  generate
    if (DIVISOR < 2) begin : g_bad_divisor
      $error("io_uart_tx: DIVISOR must be at least 2");
    end
  endgenerate

  logic                  dat_sel, cntl_sel, dat_wr, cntl_wr;
  logic                  fifo_pop, fifo_full, fifo_empty, fifo_drop;
  logic [7:0]            fifo_rd_data;
  logic [COUNT_W-1:0]    fifo_count;
  logic [31:0]           status;
  logic                  unused_bits;

  logic [TX_STATE_W-1:0] state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2:0]            idx_q, idx_d;
  logic [7:0]            shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  ovf_q, ovf_d;

  assign dat_sel     = IO_mem_addr[DAT_ADDR_BIT];
  assign cntl_sel    = IO_mem_addr[CNTL_ADDR_BIT];
  assign dat_wr      = IO_mem_wr & dat_sel;
  assign cntl_wr     = IO_mem_wr & cntl_sel;
  assign uart_tx     = tx_q;
  assign unused_bits = ^{IO_mem_addr[31:5], IO_mem_addr[2:0], IO_mem_wdata[31:8]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (dat_wr),
    .wr_data   (IO_mem_wdata[7:0]),
    .pop       (fifo_pop),
    .rd_data   (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .push_drop (fifo_drop),
    .count     (fifo_count)
  );

  // Zero-latency status / data read decode
  always_comb begin
    status                = '0;
    status[COUNT_W-1:0]   = fifo_count;
    status[IDLE_BIT]      = fifo_empty & (state_q == TX_IDLE);
    status[FULL_BIT]      = fifo_full;
    status[OVF_BIT]       = ovf_q;
    IO_mem_rdata          = cntl_sel ? status : 32'd0;
  end

  // TX framing FSM; the line value is registered from the next state so the
  // start bit appears one edge after the pop
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rd_data;
          cnt_d    = BIT_LAST;
          state_d  = TX_START;
        end
      end
      TX_START: begin
        if (cnt_q == '0) begin
          cnt_d   = BIT_LAST;
          idx_d   = 3'd0;
          state_d = TX_DATA;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      TX_DATA: begin
        if (cnt_q == '0) begin
          cnt_d   = BIT_LAST;
          shift_d = {1'b0, shift_q[7:1]};
          if (idx_q == 3'd7) state_d = TX_STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      TX_STOP: begin
        if (cnt_q == '0) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rd_data;
            cnt_d    = BIT_LAST;
            state_d  = TX_START;
          end else begin
            cnt_d   = '0;
            state_d = TX_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = TX_IDLE;
      end
    endcase

    case (state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  // Sticky overflow: a dropped push wins over a same-cycle clear
  always_comb begin
    ovf_d = ovf_q;
    if (cntl_wr)   ovf_d = 1'b0;
    if (fifo_drop) ovf_d = 1'b1;
  end

  // State registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule : io_uart_tx
`default_nettype wire
